// File: rtl/fpsqrt_r4_ctrl.sv
// Radix-4 square-root sequencer: IDLE -> PRE -> ITER x N -> POST -> DONE; accept-to-result N+3 cycles, 3 when special.
// Backpressure: start_ready_o only in IDLE; DONE holds finish_valid_o until finish_ready_i. flush_i aborts from any state.
module fpsqrt_r4_ctrl #(
    parameter int F16_ITER = 6,
    parameter int F32_ITER = 13,
    parameter int F64_ITER = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid_i,
    output logic       start_ready_o,
    input  logic [1:0] fp_format_i,
    input  logic       special_case_i,
    input  logic       flush_i,
    input  logic [4:0] rt_dig_i,
    output logic       pre_en_o,
    output logic       iter_en_o,
    output logic       iter_first_o,
    output logic       iter_last_o,
    output logic [4:0] iter_cnt_o,
    output logic       post_en_o,
    output logic       finish_valid_o,
    input  logic       finish_ready_i,
    output logic       dig_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] C_F16_N = 5'(F16_ITER);
    localparam logic [4:0] C_F32_N = 5'(F32_ITER);
    localparam logic [4:0] C_F64_N = 5'(F64_ITER);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_fmt;
    logic       r_special;
    logic [4:0] r_cnt;
    logic       r_dig_err;
    logic       w_accept;
    logic [4:0] w_n_iter;
    logic       w_dig_onehot;

    assign w_accept = start_valid_i && (r_state == S_IDLE) && !flush_i;

    // Reserved encoding 11 runs as f64.
    always_comb begin
        w_n_iter = C_F64_N;
        case (r_fmt)
            2'b00:   w_n_iter = C_F16_N;
            2'b01:   w_n_iter = C_F32_N;
            default: w_n_iter = C_F64_N;
        endcase
    end

    assign w_dig_onehot = (rt_dig_i != 5'd0) && ((rt_dig_i & (rt_dig_i - 5'd1)) == 5'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_PRE;
            S_PRE:  w_state_nxt = r_special ? S_POST : S_ITER;
            S_ITER: if (r_cnt == 5'd0) w_state_nxt = S_POST;
            S_POST: w_state_nxt = S_DONE;
            S_DONE: if (finish_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fmt     <= 2'b00;
            r_special <= 1'b0;
        end else if (w_accept) begin
            r_fmt     <= fp_format_i;
            r_special <= special_case_i;
        end
    end

    // Counter rests at zero everywhere except the PRE->ITER load and the ITER countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 5'd0;
        end else if (flush_i) begin
            r_cnt <= 5'd0;
        end else if (r_state == S_PRE && !r_special) begin
            r_cnt <= w_n_iter - 5'd1;
        end else if (r_state == S_ITER && r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
        end else begin
            r_cnt <= 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_err <= 1'b0;
        end else if (flush_i || w_accept) begin
            r_dig_err <= 1'b0;
        end else if (r_state == S_ITER && !w_dig_onehot) begin
            r_dig_err <= 1'b1;
        end
    end

    assign start_ready_o  = (r_state == S_IDLE);
    assign pre_en_o       = (r_state == S_PRE);
    assign iter_en_o      = (r_state == S_ITER);
    assign iter_first_o   = (r_state == S_ITER) && (r_cnt == w_n_iter - 5'd1);
    assign iter_last_o    = (r_state == S_ITER) && (r_cnt == 5'd0);
    assign iter_cnt_o     = (r_state == S_ITER) ? r_cnt : 5'd0;
    assign post_en_o      = (r_state == S_POST);
    assign finish_valid_o = (r_state == S_DONE);
    assign dig_err_o      = r_dig_err;

endmodule

// File: tb/tb_fpsqrt_r4_ctrl.sv
// Randomized bench for fpsqrt_r4_ctrl: every cycle's outputs are compared against a
// timeline model indexed by cycles since accept.
module tb_fpsqrt_r4_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid_i = 1'b0;
    logic       start_ready_o;
    logic [1:0] fp_format_i = 2'b00;
    logic       special_case_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [4:0] rt_dig_i = 5'b00100;
    logic       pre_en_o;
    logic       iter_en_o;
    logic       iter_first_o;
    logic       iter_last_o;
    logic [4:0] iter_cnt_o;
    logic       post_en_o;
    logic       finish_valid_o;
    logic       finish_ready_i = 1'b0;
    logic       dig_err_o;

    int vectors = 0;
    int miscompares = 0;
    bit m_err = 1'b0;

    fpsqrt_r4_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .fp_format_i    (fp_format_i),
        .special_case_i (special_case_i),
        .flush_i        (flush_i),
        .rt_dig_i       (rt_dig_i),
        .pre_en_o       (pre_en_o),
        .iter_en_o      (iter_en_o),
        .iter_first_o   (iter_first_o),
        .iter_last_o    (iter_last_o),
        .iter_cnt_o     (iter_cnt_o),
        .post_en_o      (post_en_o),
        .finish_valid_o (finish_valid_o),
        .finish_ready_i (finish_ready_i),
        .dig_err_o      (dig_err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {start_ready, pre, iter, first, last, cnt[4:0], post, finish_valid, dig_err}
    function automatic logic [12:0] outs();
        return {start_ready_o, pre_en_o, iter_en_o, iter_first_o, iter_last_o,
                iter_cnt_o, post_en_o, finish_valid_o, dig_err_o};
    endfunction

    // k = cycles since accept (0 = idle); PRE at 1, iterations at 2..n+1, POST next, then DONE.
    function automatic logic [12:0] model(int k, int n, bit spec, bit err);
        logic [4:0] cnt;
        bit sr, pre, it, fi, la, po, fv;
        int post_k;
        cnt = 5'd0; sr = 0; pre = 0; it = 0; fi = 0; la = 0; po = 0; fv = 0;
        post_k = spec ? 2 : n + 2;
        if (k == 0) sr = 1;
        else if (k == 1) pre = 1;
        else if (k < post_k) begin
            it  = 1;
            cnt = 5'(n + 1 - k);
            fi  = (k == 2);
            la  = (k == n + 1);
        end else if (k == post_k) po = 1;
        else fv = 1;
        return {sr, pre, it, fi, la, cnt, po, fv, err};
    endfunction

    function automatic logic [4:0] rand_dig(int bad_pct);
        if ($urandom_range(0, 99) < bad_pct) return 5'($urandom);
        return 5'b00001 << $urandom_range(0, 4);
    endfunction

    task automatic test_op(input logic [1:0] fmt, input bit spec, input int rdy_dly,
                           input int bad_pct, input int bad_at, input int flush_at,
                           input string name);
        int n, last, done_cnt;
        bit handshake, flushed;
        logic [12:0] exp, obs;
        n = (fmt == 2'b00) ? 6 : (fmt == 2'b01) ? 13 : 27;
        last = spec ? 3 : n + 3;
        exp = model(0, n, spec, m_err);
        obs = outs();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s k=0 got %b expected %b", name, obs, exp);
        end
        start_valid_i  = 1'b1;
        fp_format_i    = fmt;
        special_case_i = spec;
        rt_dig_i       = rand_dig(bad_pct);
        flush_i        = 1'b0;
        finish_ready_i = 1'($urandom_range(0, 1));
        step();
        m_err = 1'b0;
        done_cnt = 0; handshake = 0; flushed = 0;
        for (int k = 1; k < 200 && !handshake && !flushed; k++) begin
            exp = model(k, n, spec, m_err);
            obs = outs();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s k=%0d got %b expected %b", name, k, obs, exp);
            end
            start_valid_i  = 1'($urandom_range(0, 1));
            fp_format_i    = 2'($urandom);
            special_case_i = 1'($urandom);
            rt_dig_i       = (k == bad_at) ? 5'b00110 : rand_dig(bad_pct);
            flush_i        = (k == flush_at);
            finish_ready_i = (k >= last) ? (done_cnt >= rdy_dly) : 1'($urandom_range(0, 1));
            if (k >= last) done_cnt++;
            if (flush_i) flushed = 1;
            else if (k >= last && finish_ready_i) handshake = 1;
            if (exp[10] && $countones(rt_dig_i) != 1) m_err = 1'b1;
            step();
        end
        if (flushed) m_err = 1'b0;
        start_valid_i  = 1'b0;
        flush_i        = 1'b0;
        finish_ready_i = 1'b0;
        exp = model(0, n, spec, m_err);
        obs = outs();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s return-to-idle got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        exp = model(0, 6, 0, 0);
        #3;
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_held got %b expected %b", outs(), exp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_release got %b expected %b", outs(), exp);
        end
    endtask

    task automatic test_f32();
        test_op(2'b01, 1'b0, 0, 0, -1, -1, "f32_timeline");
    endtask

    task automatic test_special_f64();
        test_op(2'b10, 1'b1, 0, 0, -1, -1, "special_f64");
    endtask

    task automatic test_done_hold();
        test_op(2'b01, 1'b0, 5, 0, -1, -1, "done_hold");
    endtask

    task automatic test_dig_err();
        test_op(2'b00, 1'b0, 2, 0, 4, -1, "f16_dig_err");
        test_op(2'b00, 1'b0, 0, 0, -1, -1, "dig_err_clear");
    endtask

    task automatic test_reserved_fmt();
        test_op(2'b11, 1'b0, 1, 0, -1, -1, "reserved_fmt");
    endtask

    task automatic test_flush();
        test_op(2'b01, 1'b0, 0, 0, -1, 5, "flush_iter");
        test_op(2'b01, 1'b0, 0, 0, -1, -1, "after_flush");
    endtask

    task automatic test_flush_idle();
        logic [12:0] exp;
        exp = model(0, 6, 0, m_err);
        start_valid_i = 1'b1;
        flush_i       = 1'b1;
        step();
        flush_i       = 1'b0;
        start_valid_i = 1'b0;
        exp = model(0, 6, 0, 0);
        m_err = 1'b0;
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL flush_idle_accept got %b expected %b", outs(), exp);
        end
        step();
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL flush_idle_next got %b expected %b", outs(), exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp;
        start_valid_i  = 1'b1;
        fp_format_i    = 2'b10;
        special_case_i = 1'b0;
        rt_dig_i       = 5'b00010;
        step();
        start_valid_i = 1'b0;
        repeat (4) step();
        exp = model(5, 27, 0, 0);
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid_pre got %b expected %b", outs(), exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_err = 1'b0;
        exp = model(0, 27, 0, 0);
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid_async got %b expected %b", outs(), exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            vectors++;
            if (outs() !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_after cyc=%0d got %b expected %b", i, outs(), exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_op(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 4), 10, -1,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : -1,
                    "random_op");
        end
    endtask

    initial begin
        test_reset();
        test_f32();
        test_special_f64();
        test_done_hold();
        test_dig_err();
        test_reserved_fmt();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
